bin_growing_average: RTL
========================

# bin_growing_average

Per-bin running average stage placed directly downstream of the FFT bin collector. It accepts one frame of BINS collected bin magnitudes per `in_valid` pulse and accumulates each bin over 2^N_AVGS frames using a single shared adder, one bin per cycle. When the final frame is added, it emits the per-bin averages with a one-cycle `out_valid` strobe and restarts accumulation from zero.

## Interface
- `N`, 16, width of each bin sample (unsigned)
- `N_AVGS`, 7, log2 of frames averaged; legal range 1..16
- `BINS`, 4, number of bins per frame; must be ≥ 1
- `clk` input 1: sole clock, rising edge
- `areset` input 1: asynchronous, active-high reset
- `in_valid` input 1: one-cycle strobe, `in_data` frame valid
- `in_data` input [BINS-1:0][N-1:0]: collected bin frame
- `clear` input 1: synchronous restart of the averaging run
- `busy` output 1: high while a frame is being accumulated or dumped
- `overrun` output 1: sticky, frame dropped because `busy`
- `out_valid` output 1: one-cycle strobe, `out_data` updated
- `out_data` output [BINS-1:0][N-1:0]: per-bin averages, held until next dump

## Operation
- Internal storage: frame hold register [BINS][N]; accumulator array [BINS][N+N_AVGS] (unsigned, cannot overflow); bin index `bin_idx` (0..BINS-1); frame counter `frame_cnt` (0..2^N_AVGS-1).
- States:
  - IDLE: `busy`=0. On `in_valid`=1, latch `in_data` into hold register, set `bin_idx`=0, go to ADD.
  - ADD: each cycle `acc[bin_idx] <= acc[bin_idx] + hold[bin_idx]`, then `bin_idx`+1. After `bin_idx`=BINS-1: if `frame_cnt`=2^N_AVGS-1, go to DUMP; otherwise increment `frame_cnt` and go to IDLE.
  - DUMP: `out_data[k] <= avg(acc[k])` for all k; `out_valid`=1; all `acc`←0; `frame_cnt`←0; go to IDLE.
- `avg(x)` = `x >> N_AVGS` (truncating), or rounded per Configuration.
- `in_valid` outside IDLE: frame dropped; `overrun`←1; accumulation is unaffected.
- `clear`=1 (any state): `acc`←0, `frame_cnt`←0, `bin_idx`←0, `overrun`←0, state←IDLE. `out_data` holds its value; `out_valid`=0. `clear` wins over a same-cycle `in_valid` (the frame is not taken and `overrun` is not set).
- Reset values: `out_data`=0, `out_valid`=0, `busy`=0, `overrun`=0, all accumulators and counters 0, state IDLE.
- `areset` mid-ADD or mid-DUMP: the partial run is discarded and no `out_valid` is produced.

## Timing
- E0 is the edge that samples `in_valid`=1 in IDLE.
- `busy` is registered: high from E0 until the edge that returns the block to IDLE.
- Bin k is added at edge E0+1+k. The last add is at E0+BINS.
- Non-final frame: IDLE again after E0+BINS. The next frame is accepted from edge E0+BINS+1 onward, so the minimum frame spacing is BINS+1 cycles.
- Final frame: DUMP is entered at edge E0+BINS. `out_data` and `out_valid` update at edge E0+BINS+1, and `out_valid` is high for exactly one cycle. IDLE is re-entered at E0+BINS+1, so the next frame can be accepted at E0+BINS+2.
- Latency from the final `in_valid` to `out_valid`: BINS+1 edges.

## Configuration
- Macro `BIN_AVG_ROUND_EN`.
  - Defined: `avg(x) = (x + 2^(N_AVGS-1)) >> N_AVGS` (round half up). The addition is computed at N+N_AVGS width. Its maximum result is below 2^(N+N_AVGS), so it cannot wrap, and the average saturates naturally at 2^N-1.
  - Undefined: `avg(x) = x >> N_AVGS` (truncate).

## Test plan
All scenarios use N=16, N_AVGS=2, BINS=4, with frames spaced 8 cycles apart unless stated.
- Reset: assert `areset` asynchronously mid-cycle -> all outputs 0 immediately. Release, then idle 20 cycles -> `out_valid` never asserts.
- Basic average: 4 frames with bin k = 100·(k+1) -> one `out_valid` pulse exactly 5 edges after the 4th `in_valid`, `out_data` = {400,300,200,100} (bin3..bin0). A further 4 frames of all-0 -> `out_data` = 0.
- Rounding: bin0 values 1,1,1,0 over 4 frames -> `out_data[0]` = 0 without `BIN_AVG_ROUND_EN`, = 1 with it. Bin1 values 2,2,2,1 (sum 7) -> 1 without, 2 with.
- Full scale: 4 frames of all 0xFFFF -> `out_data` = 0xFFFF in every bin in both configurations, with no wrap.
- Overrun: pulse `in_valid` at E0+2 of frame 2 with bins = 0xFFFF -> `overrun`=1 and stays high. The final average equals that of the 4 accepted frames only. `clear` then drops `overrun` to 0.
- Clear/reset mid-run: 2 frames of 1000, then `clear`, then 4 frames of 40 -> `out_data` = 40 in every bin. Assert `areset` at E0+2 of the final frame -> no `out_valid`, `out_data`=0.

Source files
------------

// File: rtl/bin_growing_average_if.sv
// -----------------------------------------------------------------------------
// bin_growing_average_if
//   Frame/result bus between the FFT bin collector, the averaging stage and
//   its consumer.
//
//   Signals
//     in_valid  : one-cycle strobe, in_data carries a collected bin frame
//     in_data   : [BINS][N] bin magnitudes (unsigned)
//     clear     : synchronous restart of the averaging run
//     busy      : averaging stage is accumulating or dumping a frame
//     overrun   : sticky, a frame arrived while busy and was dropped
//     out_valid : one-cycle strobe, out_data has just been updated
//     out_data  : [BINS][N] per-bin averages, held until the next dump
//
//   Modports
//     master : frame source / result consumer
//     slave  : the averaging stage
// -----------------------------------------------------------------------------
interface bin_growing_average_if #(
    parameter int N    = 16,
    parameter int BINS = 4
);
    logic                     in_valid;
    logic [BINS-1:0][N-1:0]   in_data;
    logic                     clear;
    logic                     busy;
    logic                     overrun;
    logic                     out_valid;
    logic [BINS-1:0][N-1:0]   out_data;

    modport master (
        output in_valid, in_data, clear,
        input  busy, overrun, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, clear,
        output busy, overrun, out_valid, out_data
    );
endinterface

// File: rtl/bin_growing_average.sv
// -----------------------------------------------------------------------------
// bin_growing_average
//   Per-bin running average placed after the FFT bin collector. Each accepted
//   frame of BINS samples is added into a per-bin accumulator through one
//   shared adder, one bin per cycle. After 2^N_AVGS frames the accumulators
//   are scaled down into out_data, out_valid pulses for one cycle and the
//   run restarts from zero.
//
//   Parameters
//     N      : bin sample width (unsigned)
//     N_AVGS : log2 of the number of frames averaged (1..16)
//     BINS   : bins per frame (>= 1)
//
//   Ports
//     clk    : sole clock, rising edge
//     areset : asynchronous, active-high reset
//     bus    : bin_growing_average_if.slave (frame in, averages out, status)
//
//   Build option
//     BIN_AVG_ROUND_EN : when defined, averages round half up instead of
//                        truncating.
// -----------------------------------------------------------------------------
module bin_growing_average #(
    parameter int N      = 16,
    parameter int N_AVGS = 7,
    parameter int BINS   = 4
) (
    input  logic                   clk,
    input  logic                   areset,
    bin_growing_average_if.slave   bus
);

    localparam int ACC_W = N + N_AVGS;
    localparam int IDX_W = (BINS > 1) ? $clog2(BINS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DUMP
    } state_t;

    state_t                  state_q, state_next;

    logic [BINS-1:0][N-1:0]  hold_q;
    logic [ACC_W-1:0]        acc_q [BINS];
    logic [IDX_W-1:0]        bin_idx_q;
    logic [N_AVGS-1:0]       frame_cnt_q;

    logic                    busy_q;
    logic                    overrun_q;
    logic                    out_valid_q;
    logic [BINS-1:0][N-1:0]  out_data_q;

    // Control decoded from the current state and inputs.
    logic                    take_frame;
    logic                    do_add;
    logic                    do_dump;
    logic                    drop_frame;
    logic                    last_bin;
    logic                    last_frame;
    logic [ACC_W-1:0]        acc_sum;

    assign last_bin   = (bin_idx_q == IDX_W'(BINS - 1));
    assign last_frame = (frame_cnt_q == '1);

    // The one shared adder: the bin currently selected by bin_idx.
    assign acc_sum = acc_q[bin_idx_q] + ACC_W'(hold_q[bin_idx_q]);

`ifdef BIN_AVG_ROUND_EN
    // Half an LSB of the result, added before the shift. The sum cannot wrap
    // at ACC_W bits, so a full-scale input still averages to 2^N-1.
    localparam logic [ACC_W-1:0] ROUND_BIAS = ACC_W'(1) << (N_AVGS - 1);

    function automatic logic [N-1:0] avg(input logic [ACC_W-1:0] x);
        return N'((x + ROUND_BIAS) >> N_AVGS);
    endfunction
`else
    function automatic logic [N-1:0] avg(input logic [ACC_W-1:0] x);
        return N'(x >> N_AVGS);
    endfunction
`endif

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            // busy tracks the state being entered, so it is a clean flop output.
            busy_q  <= (state_next != S_IDLE);
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and datapath controls
    // -------------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state_q;
        take_frame = 1'b0;
        do_add     = 1'b0;
        do_dump    = 1'b0;
        drop_frame = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    take_frame = 1'b1;
                    state_next = S_ADD;
                end
            end
            S_ADD: begin
                do_add     = 1'b1;
                drop_frame = bus.in_valid;
                if (last_bin) begin
                    state_next = last_frame ? S_DUMP : S_IDLE;
                end
            end
            S_DUMP: begin
                do_dump    = 1'b1;
                drop_frame = bus.in_valid;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // clear overrides everything, including a same-cycle frame.
        if (bus.clear) begin
            state_next = S_IDLE;
            take_frame = 1'b0;
            do_add     = 1'b0;
            do_dump    = 1'b0;
            drop_frame = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    // NOTE: the accumulator array is reset explicitly; a run must always start
    // from zero, so it cannot be left to power-up contents like a plain RAM.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            hold_q      <= '0;
            bin_idx_q   <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int k = 0; k < BINS; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            out_valid_q <= do_dump;

            if (bus.clear) begin
                bin_idx_q   <= '0;
                frame_cnt_q <= '0;
                overrun_q   <= 1'b0;
                for (int k = 0; k < BINS; k++) begin
                    acc_q[k] <= '0;
                end
            end else begin
                if (take_frame) begin
                    hold_q    <= bus.in_data;
                    bin_idx_q <= '0;
                end

                if (do_add) begin
                    acc_q[bin_idx_q] <= acc_sum;
                    if (last_bin) begin
                        bin_idx_q <= '0;
                        // The final frame's counter wrap happens in DUMP.
                        if (!last_frame) begin
                            frame_cnt_q <= frame_cnt_q + 1'b1;
                        end
                    end else begin
                        bin_idx_q <= bin_idx_q + 1'b1;
                    end
                end

                if (do_dump) begin
                    frame_cnt_q <= '0;
                    for (int k = 0; k < BINS; k++) begin
                        out_data_q[k] <= avg(acc_q[k]);
                        acc_q[k]      <= '0;
                    end
                end

                if (drop_frame) begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule
